// File: rtl/rvfi_insn_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_insn_monitor
// Brief    : Registered RVFI retire checker against per-channel spec models,
//            with retire-order continuity supervision and sticky first error.
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_insn_monitor #(
    parameter int NRET        = 1,
    parameter int XLEN        = 32,
    parameter int ORDER_W     = 8,
    parameter int CHECK_ORDER = 1,
    parameter int CHECK_MEM   = 1,
    parameter int CNT_W       = 32
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    enable,
    input  logic                                    clear,
    input  logic [NRET-1:0]                         rvfi_valid,
    input  logic [NRET-1:0]                         rvfi_post_trap,
    input  logic [NRET*ORDER_W-1:0]                 rvfi_order,
    input  logic [NRET*5-1:0]                       rvfi_rs1,
    input  logic [NRET*5-1:0]                       rvfi_rs2,
    input  logic [NRET*5-1:0]                       rvfi_rd,
    input  logic [NRET*XLEN-1:0]                    rvfi_post_pc,
    input  logic [NRET*XLEN-1:0]                    rvfi_post_rd,
    input  logic [NRET*XLEN-1:0]                    rvfi_mem_addr,
    input  logic [NRET*XLEN-1:0]                    rvfi_mem_rdata,
    input  logic [NRET*XLEN-1:0]                    rvfi_mem_wdata,
    input  logic [NRET*XLEN/8-1:0]                  rvfi_mem_rmask,
    input  logic [NRET*XLEN/8-1:0]                  rvfi_mem_wmask,
    input  logic [NRET-1:0]                         spec_valid,
    input  logic [NRET-1:0]                         spec_post_trap,
    input  logic [NRET*5-1:0]                       spec_rs1,
    input  logic [NRET*5-1:0]                       spec_rs2,
    input  logic [NRET*5-1:0]                       spec_rd,
    input  logic [NRET*XLEN-1:0]                    spec_post_pc,
    input  logic [NRET*XLEN-1:0]                    spec_post_rd,
    input  logic [NRET*XLEN-1:0]                    spec_mem_addr,
    input  logic [NRET*XLEN-1:0]                    spec_mem_wdata,
    input  logic [NRET*XLEN/8-1:0]                  spec_mem_rmask,
    input  logic [NRET*XLEN/8-1:0]                  spec_mem_wmask,
    output logic                                    err,
    output logic [3:0]                              err_code,
    output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] err_chan,
    output logic [ORDER_W-1:0]                      err_order,
    output logic [CNT_W-1:0]                        checked_count,
    output logic [1:0]                              state
);

    localparam int c_CHAN_W = (NRET > 1) ? $clog2(NRET) : 1;
    localparam int c_LANES  = XLEN / 8;
    localparam int c_POP_W  = $clog2(NRET + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FAIL = 2'd2;

    logic [1:0]          r_state;
    logic                r_err;
    logic [3:0]          r_err_code;
    logic [c_CHAN_W-1:0] r_err_chan;
    logic [ORDER_W-1:0]  r_err_order;
    logic [CNT_W-1:0]    r_count;
    logic [ORDER_W-1:0]  r_expected;

    logic [NRET-1:0]     w_live;
    logic [NRET-1:0]     w_chk;
    logic [3:0]          w_code [NRET];

    assign w_live = enable ? rvfi_valid : '0;
    assign w_chk  = w_live & spec_valid;

    for (genvar gi = 0; gi < NRET; gi++) begin : g_chan
        logic [4:0]         w_s_rs1;
        logic [4:0]         w_s_rs2;
        logic [c_LANES-1:0] w_swm;
        logic [c_LANES-1:0] w_srm;
        logic [c_LANES-1:0] w_wm;
        logic [c_LANES-1:0] w_rm;
        logic [XLEN-1:0]    w_wd;
        logic [XLEN-1:0]    w_swd;
        logic [XLEN-1:0]    w_rdat;
        logic [ORDER_W-1:0] w_exp_i;
        logic               w_body;
        logic               w_mem_on;
        logic               w_mem7;
        logic               w_mem8;
        logic               w_gap;
        logic               w_e1, w_e2, w_e3, w_e4, w_e5, w_e6, w_e7, w_e8, w_e9, w_e10;
        logic [3:0]         w_c;

        assign w_s_rs1 = spec_rs1[gi*5 +: 5];
        assign w_s_rs2 = spec_rs2[gi*5 +: 5];
        assign w_swm   = spec_mem_wmask[gi*c_LANES +: c_LANES];
        assign w_srm   = spec_mem_rmask[gi*c_LANES +: c_LANES];
        assign w_wm    = rvfi_mem_wmask[gi*c_LANES +: c_LANES];
        assign w_rm    = rvfi_mem_rmask[gi*c_LANES +: c_LANES];
        assign w_wd    = rvfi_mem_wdata[gi*XLEN +: XLEN];
        assign w_swd   = spec_mem_wdata[gi*XLEN +: XLEN];
        assign w_rdat  = rvfi_mem_rdata[gi*XLEN +: XLEN];
        assign w_exp_i = r_expected + ORDER_W'(gi);

        if (gi == 0) begin : g_head
            assign w_gap = 1'b0;
        end else begin : g_tail
            assign w_gap = !w_live[gi-1];
        end

        // Lanes the core wrote but the spec did not must be read back unchanged.
        always_comb begin
            w_mem7 = 1'b0;
            w_mem8 = 1'b0;
            for (int b = 0; b < c_LANES; b++) begin
                if (w_swm[b] && (!w_wm[b] || (w_wd[b*8 +: 8] != w_swd[b*8 +: 8])))
                    w_mem7 = 1'b1;
                if (!w_swm[b] && w_wm[b] && (!w_rm[b] || (w_rdat[b*8 +: 8] != w_wd[b*8 +: 8])))
                    w_mem7 = 1'b1;
                if (w_srm[b] && !w_rm[b])
                    w_mem8 = 1'b1;
            end
        end

        assign w_body   = !spec_post_trap[gi];
        assign w_mem_on = (CHECK_MEM != 0) && w_body;
        assign w_e1  = (w_s_rs1 != 5'd0) && (w_s_rs1 != rvfi_rs1[gi*5 +: 5]);
        assign w_e2  = (w_s_rs2 != 5'd0) && (w_s_rs2 != rvfi_rs2[gi*5 +: 5]);
        assign w_e3  = w_body && (spec_rd[gi*5 +: 5] != rvfi_rd[gi*5 +: 5]);
        assign w_e4  = w_body && (spec_post_rd[gi*XLEN +: XLEN] != rvfi_post_rd[gi*XLEN +: XLEN]);
        assign w_e5  = w_body && (spec_post_pc[gi*XLEN +: XLEN] != rvfi_post_pc[gi*XLEN +: XLEN]);
        assign w_e6  = w_mem_on && ((w_swm | w_srm) != '0)
                       && (spec_mem_addr[gi*XLEN +: XLEN] != rvfi_mem_addr[gi*XLEN +: XLEN]);
        assign w_e7  = w_mem_on && w_mem7;
        assign w_e8  = w_mem_on && w_mem8;
        assign w_e9  = spec_post_trap[gi] != rvfi_post_trap[gi];
        assign w_e10 = (CHECK_ORDER != 0) && w_live[gi] && (r_state == c_RUN)
                       && (w_gap || (rvfi_order[gi*ORDER_W +: ORDER_W] != w_exp_i));

        always_comb begin
            w_c = 4'd0;
            if (w_chk[gi]) begin
                if      (w_e1) w_c = 4'd1;
                else if (w_e2) w_c = 4'd2;
                else if (w_e3) w_c = 4'd3;
                else if (w_e4) w_c = 4'd4;
                else if (w_e5) w_c = 4'd5;
                else if (w_e6) w_c = 4'd6;
                else if (w_e7) w_c = 4'd7;
                else if (w_e8) w_c = 4'd8;
                else if (w_e9) w_c = 4'd9;
            end
            if ((w_c == 4'd0) && w_e10)
                w_c = 4'd10;
        end

        assign w_code[gi] = w_c;
    end

    logic                w_any_err;
    logic [c_CHAN_W-1:0] w_f_chan;
    logic [3:0]          w_f_code;
    logic [ORDER_W-1:0]  w_f_order;
    logic [c_POP_W-1:0]  w_pop;
    logic [c_POP_W-1:0]  w_nchk;

    // Scan from the top so the lowest failing channel is the one left standing.
    always_comb begin
        w_any_err = 1'b0;
        w_f_chan  = '0;
        w_f_code  = 4'd0;
        w_f_order = '0;
        w_pop     = '0;
        w_nchk    = '0;
        for (int i = NRET - 1; i >= 0; i--) begin
            if (w_code[i] != 4'd0) begin
                w_any_err = 1'b1;
                w_f_chan  = c_CHAN_W'(i);
                w_f_code  = w_code[i];
                w_f_order = rvfi_order[i*ORDER_W +: ORDER_W];
            end
            w_pop  = w_pop + c_POP_W'(w_live[i]);
            w_nchk = w_nchk + c_POP_W'(w_chk[i]);
        end
    end

    logic [CNT_W:0]      w_cnt_sum;
    logic [CNT_W-1:0]    w_cnt_sat;
    logic [ORDER_W-1:0]  w_exp_load;
    logic [ORDER_W-1:0]  w_exp_plus;

    assign w_cnt_sum  = {1'b0, r_count} + (CNT_W + 1)'(w_nchk);
    assign w_cnt_sat  = w_cnt_sum[CNT_W] ? c_CNT_MAX : w_cnt_sum[CNT_W-1:0];
    assign w_exp_load = rvfi_order[ORDER_W-1:0] + ORDER_W'(w_pop);
    assign w_exp_plus = r_expected + ORDER_W'(w_pop);

    logic [1:0]          w_state_nxt;
    logic                w_latch;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [ORDER_W-1:0]  w_exp_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_cnt_nxt   = r_count;
        w_exp_nxt   = r_expected;
        if (clear) begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
            w_exp_nxt   = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_err) begin
                        w_state_nxt = c_FAIL;
                        w_latch     = 1'b1;
                    end else if (|w_live) begin
                        w_state_nxt = c_RUN;
                        w_exp_nxt   = w_exp_load;
                        w_cnt_nxt   = w_cnt_sat;
                    end
                end
                c_RUN: begin
                    if (w_any_err) begin
                        w_state_nxt = c_FAIL;
                        w_latch     = 1'b1;
                    end else begin
                        w_exp_nxt = w_exp_plus;
                        w_cnt_nxt = w_cnt_sat;
                    end
                end
                c_FAIL: begin
                    w_state_nxt = c_FAIL;
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_IDLE;
            r_err       <= 1'b0;
            r_err_code  <= 4'd0;
            r_err_chan  <= '0;
            r_err_order <= '0;
            r_count     <= '0;
            r_expected  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_cnt_nxt;
            r_expected <= w_exp_nxt;
            if (clear) begin
                r_err       <= 1'b0;
                r_err_code  <= 4'd0;
                r_err_chan  <= '0;
                r_err_order <= '0;
            end else if (w_latch) begin
                r_err       <= 1'b1;
                r_err_code  <= w_f_code;
                r_err_chan  <= w_f_chan;
                r_err_order <= w_f_order;
            end
        end
    end

    assign err           = r_err;
    assign err_code      = r_err_code;
    assign err_chan      = r_err_chan;
    assign err_order     = r_err_order;
    assign checked_count = r_count;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_insn_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvfi_insn_monitor
// Brief    : Randomized bench for rvfi_insn_monitor with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvfi_insn_monitor;

    localparam int NRET    = 2;
    localparam int XLEN    = 32;
    localparam int ORDER_W = 8;
    localparam int CNT_W   = 6;
    localparam int LANES   = XLEN / 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    logic enable = 1'b0;
    logic clear  = 1'b0;

    logic [NRET-1:0]         rvfi_valid = '0, rvfi_post_trap = '0, spec_valid = '0, spec_post_trap = '0;
    logic [NRET*ORDER_W-1:0] rvfi_order = '0;
    logic [NRET*5-1:0]       rvfi_rs1 = '0, rvfi_rs2 = '0, rvfi_rd = '0;
    logic [NRET*5-1:0]       spec_rs1 = '0, spec_rs2 = '0, spec_rd = '0;
    logic [NRET*XLEN-1:0]    rvfi_post_pc = '0, rvfi_post_rd = '0, rvfi_mem_addr = '0;
    logic [NRET*XLEN-1:0]    rvfi_mem_rdata = '0, rvfi_mem_wdata = '0;
    logic [NRET*XLEN-1:0]    spec_post_pc = '0, spec_post_rd = '0, spec_mem_addr = '0, spec_mem_wdata = '0;
    logic [NRET*LANES-1:0]   rvfi_mem_rmask = '0, rvfi_mem_wmask = '0, spec_mem_rmask = '0, spec_mem_wmask = '0;

    logic               err;
    logic [3:0]         err_code;
    logic               err_chan;
    logic [ORDER_W-1:0] err_order;
    logic [CNT_W-1:0]   checked_count;
    logic [1:0]         state;

    rvfi_insn_monitor #(
        .NRET(NRET), .XLEN(XLEN), .ORDER_W(ORDER_W),
        .CHECK_ORDER(1), .CHECK_MEM(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
        .rvfi_valid(rvfi_valid), .rvfi_post_trap(rvfi_post_trap), .rvfi_order(rvfi_order),
        .rvfi_rs1(rvfi_rs1), .rvfi_rs2(rvfi_rs2), .rvfi_rd(rvfi_rd),
        .rvfi_post_pc(rvfi_post_pc), .rvfi_post_rd(rvfi_post_rd),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask),
        .spec_valid(spec_valid), .spec_post_trap(spec_post_trap),
        .spec_rs1(spec_rs1), .spec_rs2(spec_rs2), .spec_rd(spec_rd),
        .spec_post_pc(spec_post_pc), .spec_post_rd(spec_post_rd),
        .spec_mem_addr(spec_mem_addr), .spec_mem_wdata(spec_mem_wdata),
        .spec_mem_rmask(spec_mem_rmask), .spec_mem_wmask(spec_mem_wmask),
        .err(err), .err_code(err_code), .err_chan(err_chan), .err_order(err_order),
        .checked_count(checked_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Error class of one channel, straight from the checking rules.
    function automatic logic [3:0] chan_code(input int i, input bit run,
                                             input logic [1:0] live, input logic [7:0] exp);
        logic [4:0] s1, s2;
        logic [LANES-1:0] sw, sr, w, r;
        logic [XLEN-1:0] wd, swd, rd;
        if (!live[i]) return 4'd0;
        if (spec_valid[i]) begin
            s1 = spec_rs1[i*5 +: 5];
            s2 = spec_rs2[i*5 +: 5];
            if (s1 != 0 && s1 != rvfi_rs1[i*5 +: 5]) return 4'd1;
            if (s2 != 0 && s2 != rvfi_rs2[i*5 +: 5]) return 4'd2;
            if (!spec_post_trap[i]) begin
                if (spec_rd[i*5 +: 5] != rvfi_rd[i*5 +: 5]) return 4'd3;
                if (spec_post_rd[i*XLEN +: XLEN] != rvfi_post_rd[i*XLEN +: XLEN]) return 4'd4;
                if (spec_post_pc[i*XLEN +: XLEN] != rvfi_post_pc[i*XLEN +: XLEN]) return 4'd5;
                sw = spec_mem_wmask[i*LANES +: LANES];
                sr = spec_mem_rmask[i*LANES +: LANES];
                w  = rvfi_mem_wmask[i*LANES +: LANES];
                r  = rvfi_mem_rmask[i*LANES +: LANES];
                wd = rvfi_mem_wdata[i*XLEN +: XLEN];
                swd = spec_mem_wdata[i*XLEN +: XLEN];
                rd = rvfi_mem_rdata[i*XLEN +: XLEN];
                if ((sw | sr) != 0 && spec_mem_addr[i*XLEN +: XLEN] != rvfi_mem_addr[i*XLEN +: XLEN])
                    return 4'd6;
                for (int b = 0; b < LANES; b++) begin
                    if (sw[b] && (!w[b] || wd[b*8 +: 8] != swd[b*8 +: 8])) return 4'd7;
                    if (!sw[b] && w[b] && (!r[b] || rd[b*8 +: 8] != wd[b*8 +: 8])) return 4'd7;
                end
                for (int b = 0; b < LANES; b++)
                    if (sr[b] && !r[b]) return 4'd8;
            end
            if (spec_post_trap[i] != rvfi_post_trap[i]) return 4'd9;
        end
        if (run) begin
            if (i > 0 && !live[i-1]) return 4'd10;
            if (rvfi_order[i*ORDER_W +: ORDER_W] != exp + 8'(i)) return 4'd10;
        end
        return 4'd0;
    endfunction

    int         m_state, mn_state, m_count, mn_count;
    logic       m_err, mn_err, m_chan, mn_chan;
    logic [3:0] m_code, mn_code;
    logic [7:0] m_order, mn_order, m_exp, mn_exp;
    logic [1:0] m_live;
    int         m_nlive, m_nchk, m_fch;
    logic [3:0] m_fcode, m_c;

    always_comb begin
        mn_state = m_state; mn_err = m_err; mn_code = m_code; mn_chan = m_chan;
        mn_order = m_order; mn_count = m_count; mn_exp = m_exp;
        m_live = enable ? rvfi_valid : 2'b00;
        m_nlive = 0; m_nchk = 0; m_fch = -1; m_fcode = 4'd0; m_c = 4'd0;
        for (int i = 0; i < NRET; i++) begin
            if (m_live[i]) m_nlive = m_nlive + 1;
            if (m_live[i] && spec_valid[i]) m_nchk = m_nchk + 1;
            m_c = chan_code(i, m_state == 1, m_live, m_exp);
            if (m_c != 0 && m_fch < 0) begin
                m_fch = i;
                m_fcode = m_c;
            end
        end
        if (m_state != 2) begin
            if (m_fch >= 0) begin
                mn_state = 2; mn_err = 1'b1; mn_code = m_fcode; mn_chan = m_fch[0];
                mn_order = rvfi_order[m_fch*ORDER_W +: ORDER_W];
            end else if (m_nlive > 0) begin
                mn_state = 1;
                mn_exp = ((m_state == 0) ? rvfi_order[7:0] : m_exp) + 8'(m_nlive);
                mn_count = (m_count + m_nchk > CNT_MAX) ? CNT_MAX : m_count + m_nchk;
            end
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn || clear) begin
            m_state <= 0; m_err <= 1'b0; m_code <= 4'd0; m_chan <= 1'b0;
            m_order <= 8'd0; m_count <= 0; m_exp <= 8'd0;
        end else begin
            m_state <= mn_state; m_err <= mn_err; m_code <= mn_code; m_chan <= mn_chan;
            m_order <= mn_order; m_count <= mn_count; m_exp <= mn_exp;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("state", 64'(state), 64'(m_state));
            check("err", 64'(err), 64'(m_err));
            check("err_code", 64'(err_code), 64'(m_code));
            check("err_chan", 64'(err_chan), 64'(m_chan));
            check("err_order", 64'(err_order), 64'(m_order));
            check("checked_count", 64'(checked_count), 64'(m_count));
        end
    end

    task automatic idle_all();
        rvfi_valid = '0;
        spec_valid = '0;
    endtask

    // Fully matching retire on channel i; kind 0 ALU, 1 load, 2 store, 3 trap.
    task automatic gen_chan(input int i, input logic [7:0] ord, input int kind);
        logic [31:0] pc, val, addr, dat;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  msk;
        pc = $urandom & 32'hFFFF_FFFC; val = $urandom; addr = $urandom; dat = $urandom;
        rs1 = 5'($urandom_range(1, 31)); rs2 = 5'($urandom_range(1, 31));
        rd = (kind == 2) ? 5'd0 : 5'($urandom_range(0, 31));
        msk = 4'($urandom_range(1, 15));
        rvfi_valid[i] = 1'b1; spec_valid[i] = 1'b1;
        rvfi_order[i*ORDER_W +: ORDER_W] = ord;
        rvfi_rs1[i*5 +: 5] = rs1; spec_rs1[i*5 +: 5] = rs1;
        rvfi_rs2[i*5 +: 5] = rs2; spec_rs2[i*5 +: 5] = (kind == 2) ? rs2 : 5'd0;
        rvfi_rd[i*5 +: 5] = rd; spec_rd[i*5 +: 5] = rd;
        rvfi_post_rd[i*XLEN +: XLEN] = val; spec_post_rd[i*XLEN +: XLEN] = val;
        rvfi_post_pc[i*XLEN +: XLEN] = pc; spec_post_pc[i*XLEN +: XLEN] = pc;
        rvfi_post_trap[i] = (kind == 3); spec_post_trap[i] = (kind == 3);
        rvfi_mem_addr[i*XLEN +: XLEN] = addr; spec_mem_addr[i*XLEN +: XLEN] = addr;
        rvfi_mem_rdata[i*XLEN +: XLEN] = dat;
        rvfi_mem_wdata[i*XLEN +: XLEN] = dat; spec_mem_wdata[i*XLEN +: XLEN] = dat;
        rvfi_mem_rmask[i*LANES +: LANES] = (kind == 1) ? msk : 4'd0;
        spec_mem_rmask[i*LANES +: LANES] = (kind == 1) ? msk : 4'd0;
        rvfi_mem_wmask[i*LANES +: LANES] = (kind == 2) ? msk : 4'd0;
        spec_mem_wmask[i*LANES +: LANES] = (kind == 2) ? msk : 4'd0;
    endtask

    task automatic corrupt(input int i, input int f);
        case (f)
            0: spec_rs1[i*5 +: 5] = rvfi_rs1[i*5 +: 5] ^ 5'd1;
            1: spec_rs2[i*5 +: 5] = rvfi_rs2[i*5 +: 5] ^ 5'd2;
            2: spec_rd[i*5 +: 5] = rvfi_rd[i*5 +: 5] ^ 5'd1;
            3: rvfi_post_rd[i*XLEN +: XLEN] = rvfi_post_rd[i*XLEN +: XLEN] ^ 32'h10;
            4: rvfi_post_pc[i*XLEN +: XLEN] = rvfi_post_pc[i*XLEN +: XLEN] ^ 32'h4;
            5: rvfi_post_trap[i] = ~rvfi_post_trap[i];
            6: rvfi_mem_addr[i*XLEN +: XLEN] = rvfi_mem_addr[i*XLEN +: XLEN] ^ 32'h8;
            7: rvfi_mem_wdata[i*XLEN +: XLEN] = rvfi_mem_wdata[i*XLEN +: XLEN] ^ 32'h100;
            8: rvfi_mem_rmask[i*LANES +: LANES] = 4'd0;
            default: rvfi_mem_wmask[i*LANES +: LANES] = rvfi_mem_wmask[i*LANES +: LANES] | 4'h8;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        idle_all(); clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic store_case(input logic [3:0] rmask);
        idle_all();
        gen_chan(0, 8'd0, 0);
        spec_mem_wmask[3:0] = 4'b0011; rvfi_mem_wmask[3:0] = 4'b0111;
        spec_mem_rmask[3:0] = 4'b0000; rvfi_mem_rmask[3:0] = rmask;
        spec_mem_wdata[31:0] = 32'hA1B2_C3D4; rvfi_mem_wdata[31:0] = 32'hA1B2_C3D4;
        rvfi_mem_rdata[31:0] = 32'h00B2_0000;
        spec_mem_addr[31:0] = 32'h1000; rvfi_mem_addr[31:0] = 32'h1000;
    endtask

    initial begin
        logic [7:0] base, ord;
        logic [1:0] lv;
        int pat;
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cmp_on = 1'b1;
        tick();
        check("reset state", 64'(state), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset count", 64'(checked_count), 64'd0);

        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            idle_all(); gen_chan(0, 8'(k), 0); tick();
        end
        idle_all();
        check("addi10 state", 64'(state), 64'd1);
        check("addi10 err", 64'(err), 64'd0);
        check("addi10 count", 64'(checked_count), 64'd10);

        pulse_clear();
        for (int k = 0; k < 5; k++) begin
            idle_all(); gen_chan(0, 8'(k), 0); tick();
        end
        idle_all(); gen_chan(0, 8'd5, 0);
        spec_post_pc[31:0] = 32'h104; rvfi_post_pc[31:0] = 32'h108;
        tick();
        check("pc err", 64'(err), 64'd1);
        check("pc err_code", 64'(err_code), 64'd5);
        check("pc err_order", 64'(err_order), 64'd5);
        for (int k = 6; k < 9; k++) begin
            idle_all(); gen_chan(0, 8'(k), 0); tick();
        end
        check("frozen count", 64'(checked_count), 64'd5);

        pulse_clear();
        idle_all(); gen_chan(0, 8'd0, 0); gen_chan(1, 8'd1, 1); tick();
        gen_chan(0, 8'd2, 0); gen_chan(1, 8'd4, 2); tick();
        check("order err_code", 64'(err_code), 64'd10);
        check("order err_chan", 64'(err_chan), 64'd1);
        check("order err_order", 64'(err_order), 64'd4);

        pulse_clear();
        idle_all(); gen_chan(0, 8'd254, 0); tick();
        idle_all(); gen_chan(0, 8'd255, 3); tick();
        idle_all(); gen_chan(0, 8'd0, 1); tick();
        idle_all();
        check("wrap err", 64'(err), 64'd0);
        check("wrap count", 64'(checked_count), 64'd3);

        pulse_clear();
        store_case(4'b0100); tick();
        idle_all();
        check("store ok err", 64'(err), 64'd0);
        pulse_clear();
        store_case(4'b0000); tick();
        idle_all();
        check("store bad code", 64'(err_code), 64'd7);

        idle_all(); gen_chan(0, 8'd9, 0);
        rvfi_post_pc[31:0] = rvfi_post_pc[31:0] ^ 32'h4;
        clear = 1'b1; tick(); clear = 1'b0;
        idle_all();
        check("clear prio state", 64'(state), 64'd0);
        check("clear prio err", 64'(err), 64'd0);

        for (int k = 0; k < 70; k++) begin
            idle_all(); gen_chan(0, 8'(k), $urandom_range(0, 3)); tick();
        end
        idle_all();
        check("sat count", 64'(checked_count), 64'(CNT_MAX));
        check("sat state", 64'(state), 64'd1);

        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async rst state", 64'(state), 64'd0);
        check("async rst count", 64'(checked_count), 64'd0);
        check("async rst err", 64'(err), 64'd0);
        #1 resetn = 1'b1;
        tick();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle_all();
            clear  = (m_state == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 15) != 0);
            base   = (m_state == 1) ? m_exp : 8'($urandom);
            pat    = $urandom_range(0, 15);
            lv     = (pat >= 15) ? 2'b10 : (pat >= 10) ? 2'b11 : (pat >= 3) ? 2'b01 : 2'b00;
            for (int i = 0; i < NRET; i++) begin
                if (lv[i]) begin
                    ord = base + ((lv == 2'b10) ? 8'd0 : 8'(i));
                    if ($urandom_range(0, 24) == 0) ord = ord + 8'($urandom_range(1, 255));
                    gen_chan(i, ord, $urandom_range(0, 3));
                    if ($urandom_range(0, 9) == 0) spec_valid[i] = 1'b0;
                    if ($urandom_range(0, 19) == 0) corrupt(i, $urandom_range(0, 9));
                end
            end
            tick();
        end
        clear = 1'b0;
        idle_all();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
